// File: rtl/num_render_pkg.sv
// rtl/num_render_pkg.sv - shared glyph geometry, scan states and glyph base rule for num_render.
package num_render_pkg;

  localparam int CHAR_W_DEF = 16;
  localparam int CHAR_H_DEF = 32;

  // Codes at or above this value are not decimal digits and render blank.
  localparam logic [3:0] BCD_BLANK_MIN = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GLYPH = 2'd1,
    S_GAP   = 2'd2
  } scan_state_t;

  function automatic int glyph_base(input logic [3:0] code, input int char_h);
    return int'(code) * char_h;
  endfunction

endpackage

// File: rtl/num_render_scan.sv
// rtl/num_render_scan.sv - scan FSM walking glyph/gap columns across the digit cells of one line.
module num_render_scan
  import num_render_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int CHAR_W  = CHAR_W_DEF,
  parameter int GAP     = 2,
  parameter int COORD_W = 10,
  parameter int COL_W   = 4,
  parameter int DIG_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] posx,
  input  logic               row_ok,
  output logic [COL_W-1:0]   col,
  output logic [DIG_W-1:0]   dig,
  output logic               in_glyph
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(CHAR_W - 1);
  localparam logic [COL_W-1:0] GAP_LAST = COL_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(DIGITS - 1);

  scan_state_t        state, state_nxt, cur_state;
  logic [COL_W-1:0]   col_q, col_nxt, cur_col;
  logic [DIG_W-1:0]   dig_q, dig_nxt, cur_dig;
  logic [COORD_W-1:0] x_exp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      col_q <= '0;
      dig_q <= '0;
      x_exp <= '0;
    end else if (en) begin
      state <= state_nxt;
      col_q <= col_nxt;
      dig_q <= dig_nxt;
      x_exp <= x + 1'b1;
    end
  end

  // Registers hold the position of the next pixel; cur_* is the position of pixel x itself.
  always_comb begin
    cur_state = state;
    cur_col   = col_q;
    cur_dig   = dig_q;
    if (state == S_IDLE || x != x_exp || !row_ok) begin
      cur_state = (x == posx && row_ok) ? S_GLYPH : S_IDLE;
      cur_col   = '0;
      cur_dig   = '0;
    end
    state_nxt = cur_state;
    col_nxt   = cur_col + 1'b1;
    dig_nxt   = cur_dig;
    case (cur_state)
      S_GLYPH: begin
        if (cur_col == COL_LAST) begin
          col_nxt = '0;
          if (cur_dig == DIG_LAST) begin
            state_nxt = S_IDLE;
            dig_nxt   = '0;
          end else if (GAP == 0) begin
            dig_nxt = cur_dig + 1'b1;
          end else begin
            state_nxt = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (cur_col == GAP_LAST) begin
          state_nxt = S_GLYPH;
          col_nxt   = '0;
          dig_nxt   = cur_dig + 1'b1;
        end
      end
      default: col_nxt = '0;
    endcase
  end

  always_comb begin
    col      = cur_col;
    dig      = cur_dig;
    in_glyph = (cur_state == S_GLYPH);
  end

endmodule

// File: rtl/num_render.sv
// rtl/num_render.sv - BCD number glyph renderer, 2-cycle pixel pipeline; NUM_RENDER_LZB_EN enables leading-zero blanking.
module num_render
  import num_render_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int CHAR_W  = CHAR_W_DEF,
  parameter int CHAR_H  = CHAR_H_DEF,
  parameter int GAP     = 2,
  parameter int ROM_AW  = 10,
  parameter int ROM_DW  = 32,
  parameter int COORD_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [COORD_W-1:0]    x,
  input  logic [COORD_W-1:0]    y,
  input  logic [COORD_W-1:0]    posx,
  input  logic [COORD_W-1:0]    posy,
  input  logic                  frame_start,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value_in,
  output logic [ROM_AW-1:0]     rom_adr,
  input  logic [ROM_DW-1:0]     rom_data,
  output logic                  pix_on,
  output logic                  pix_vld
);

  localparam int COL_MAX = (CHAR_W > GAP) ? CHAR_W : GAP;
  localparam int COL_W   = (COL_MAX > 1) ? $clog2(COL_MAX) : 1;
  localparam int DIG_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BI_W    = (ROM_DW > 1) ? $clog2(ROM_DW) : 1;

  logic [4*DIGITS-1:0] shadow, disp;
  logic                pending;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow  <= '0;
      disp    <= '0;
      pending <= 1'b0;
    end else if (load && frame_start) begin
      disp    <= value_in;
      pending <= 1'b0;
    end else if (load) begin
      shadow  <= value_in;
      pending <= 1'b1;
    end else if (frame_start && pending) begin
      disp    <= shadow;
      pending <= 1'b0;
    end
  end

  logic [COORD_W:0]   row_end;
  logic [COORD_W-1:0] row;
  logic               row_ok;

  assign row_end = {1'b0, posy} + (COORD_W + 1)'(CHAR_H);
  assign row_ok  = (y >= posy) && ({1'b0, y} < row_end);
  assign row     = y - posy;

  logic [COL_W-1:0] col;
  logic [DIG_W-1:0] dig;
  logic             in_glyph;

  num_render_scan #(
    .DIGITS (DIGITS),
    .CHAR_W (CHAR_W),
    .GAP    (GAP),
    .COORD_W(COORD_W),
    .COL_W  (COL_W),
    .DIG_W  (DIG_W)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .x       (x),
    .posx    (posx),
    .row_ok  (row_ok),
    .col     (col),
    .dig     (dig),
    .in_glyph(in_glyph)
  );

  logic [3:0] code;
  logic       blank;
`ifdef NUM_RENDER_LZB_EN
  logic       zero_run;
`endif

  always_comb begin
    code  = '0;
    blank = 1'b0;
`ifdef NUM_RENDER_LZB_EN
    zero_run = 1'b1;
`endif
    for (int i = 0; i < DIGITS; i++) begin
`ifdef NUM_RENDER_LZB_EN
      zero_run = zero_run && (disp[4*(DIGITS-1-i) +: 4] == 4'd0);
`endif
      if (dig == DIG_W'(i)) begin
        code = disp[4*(DIGITS-1-i) +: 4];
`ifdef NUM_RENDER_LZB_EN
        // The least-significant digit is never blanked so a zero value still shows "0".
        blank = zero_run && (i != DIGITS - 1);
`endif
      end
    end
  end

  logic             digit_ok;
  logic             en_q, lit_ok, en_d, lit_ok_d;
  logic [COL_W-1:0] sel_col, sel_col_d;
  logic [BI_W-1:0]  bit_idx;

  assign digit_ok = (code < BCD_BLANK_MIN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_adr   <= '0;
      en_q      <= 1'b0;
      lit_ok    <= 1'b0;
      sel_col   <= '0;
      en_d      <= 1'b0;
      lit_ok_d  <= 1'b0;
      sel_col_d <= '0;
      pix_on    <= 1'b0;
      pix_vld   <= 1'b0;
    end else begin
      en_q   <= en;
      lit_ok <= en && in_glyph && digit_ok && !blank;
      if (en) begin
        sel_col <= col;
      end
      if (en && in_glyph && digit_ok) begin
        rom_adr <= ROM_AW'(glyph_base(code, CHAR_H) + int'(row));
      end
      // Second stage lines the column and qualifiers up with the ROM's registered data.
      en_d      <= en_q;
      lit_ok_d  <= lit_ok;
      sel_col_d <= sel_col;
      pix_on    <= lit_ok_d & rom_data[bit_idx];
      pix_vld   <= en_d;
    end
  end

  assign bit_idx = BI_W'(CHAR_W - 1) - BI_W'(sel_col_d);

endmodule

// File: tb/tb_num_render.sv
// tb/tb_num_render.sv - randomized self-checking bench for num_render against a pixel-geometry model.
module tb_num_render;

  localparam int DIGITS = 4;
  localparam int CW     = 16;
  localparam int CH     = 32;
  localparam int GAPW   = 2;
  localparam int PITCH  = CW + GAPW;

  logic        clk, rst, en, frame_start, load;
  logic [9:0]  x, y, posx, posy;
  logic [15:0] value_in;
  logic [9:0]  rom_adr;
  logic [31:0] rom_data;
  logic        pix_on, pix_vld;

  num_render #(
    .DIGITS(DIGITS), .CHAR_W(CW), .CHAR_H(CH), .GAP(GAPW),
    .ROM_AW(10), .ROM_DW(32), .COORD_W(10)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .x(x), .y(y), .posx(posx), .posy(posy),
    .frame_start(frame_start), .load(load), .value_in(value_in),
    .rom_adr(rom_adr), .rom_data(rom_data), .pix_on(pix_on), .pix_vld(pix_vld)
  );

  logic [31:0] rom [0:1023];
  always @(posedge clk) rom_data <= rom[rom_adr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  int          px, py;
  logic [15:0] m_disp, m_shadow;
  logic        m_pend, entered;
  int          m_adr;
  logic        q_vld1, q_on1, q_vld2, q_on2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h (x=%0d y=%0d t=%0t)", tag, got, exp, x, y, $time);
    end
  endtask

  function automatic logic [3:0] mdig(input logic [15:0] v, input int d);
    return v[4*(DIGITS-1-d) +: 4];
  endfunction

  function automatic logic lz_blank(input logic [15:0] v, input int d);
`ifdef NUM_RENDER_LZB_EN
    if (d == DIGITS - 1) return 1'b0;
    for (int k = 0; k <= d; k++) if (mdig(v, k) != 4'd0) return 1'b0;
    return 1'b1;
`else
    return (v[0] && !v[0]);
`endif
  endfunction

  task automatic model_clear();
    m_disp = 0; m_shadow = 0; m_pend = 0; entered = 0; m_adr = 0;
    q_vld1 = 0; q_on1 = 0; q_vld2 = 0; q_on2 = 0;
  endtask

  task automatic set_pos(input int nx, input int ny);
    px = nx; py = ny;
    posx = 10'(nx); posy = 10'(ny);
  endtask

  // One pixel-clock step: predict from geometry, advance the 2-deep expectation queue, check outputs.
  task automatic tick(input logic e, input int xx, input int yy,
                      input logic ld, input logic fs, input logic [15:0] val);
    int p, d, c, a, rowi;
    logic rok, on, vld_exp, on_exp;
    logic [3:0] code;
    logic [31:0] w;
    en = e; x = 10'(xx); y = 10'(yy); load = ld; frame_start = fs; value_in = val;
    on = 1'b0;
    rowi = yy - py;
    rok = (yy >= py) && (yy < py + CH);
    if (e && rok && xx == px) entered = 1'b1;
    if (e && rok && entered) begin
      p = xx - px;
      if (p >= 0 && p < DIGITS * PITCH - GAPW) begin
        d = p / PITCH;
        c = p % PITCH;
        if (c < CW) begin
          code = mdig(m_disp, d);
          if (code <= 9) begin
            a = int'(code) * CH + rowi;
            m_adr = a % 1024;
            w = rom[a];
            on = !lz_blank(m_disp, d) && w[CW-1-c];
          end
        end
      end
    end
    if (ld && fs) begin
      m_disp = val; m_pend = 0;
    end else if (ld) begin
      m_shadow = val; m_pend = 1;
    end else if (fs && m_pend) begin
      m_disp = m_shadow; m_pend = 0;
    end
    vld_exp = q_vld2; on_exp = q_on2;
    q_vld2 = q_vld1; q_on2 = q_on1;
    q_vld1 = e; q_on1 = on;
    @(posedge clk); #1;
    load = 0; frame_start = 0;
    chk("pix_vld", 32'(pix_vld), 32'(vld_exp));
    chk("pix_on", 32'(pix_on), 32'(on_exp));
    chk("rom_adr", 32'(rom_adr), 32'(m_adr));
  endtask

  task automatic do_line(input int yy, input int xs, input int xe, input int gap_pct,
                         input int ld_x, input logic [15:0] ld_val);
    entered = 0;
    for (int xx = xs; xx <= xe; xx++) begin
      if (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) tick(0, xx, yy, 0, 0, 0);
      tick(1, xx, yy, xx == ld_x, 0, ld_val);
    end
    tick(0, 0, yy, 0, 0, 0);
  endtask

  task automatic new_value(input logic [15:0] v);
    tick(0, 0, 0, 1, 0, v);
    tick(0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    logic [15:0] v;
    for (int i = 0; i < 1024; i++) rom[i] = $urandom;
    rst = 0; en = 0; x = 0; y = 0; load = 0; frame_start = 0; value_in = 0;
    set_pos(100, 50);
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pix_on", 32'(pix_on), 0);
    chk("rst_pix_vld", 32'(pix_vld), 0);
    chk("rst_rom_adr", 32'(rom_adr), 0);
    rst = 1;

    // 2048 at (100,50): address checks on the first rendered row.
    new_value(16'h2048);
    entered = 0;
    for (int xx = 95; xx <= 175; xx++) begin
      tick(1, xx, 50, 0, 0, 0);
      if (xx == 100) chk("adr_x100", 32'(rom_adr), 64);
      if (xx == 118) chk("adr_x118", 32'(rom_adr), 0);
    end
    do_line(51, 98, 175, 20, -1, 0);
    do_line(49, 100, 170, 0, -1, 0);
    do_line(82, 100, 170, 0, -1, 0);
    do_line(81, 97, 175, 0, -1, 0);

    // Mid-frame load must not tear; it takes effect at the next frame_start.
    do_line(60, 96, 175, 0, 130, 16'h0512);
    do_line(61, 96, 175, 10, -1, 0);
    tick(0, 0, 0, 0, 1, 0);
    do_line(60, 96, 175, 0, -1, 0);
    tick(0, 0, 0, 1, 1, 16'h20A8);
    do_line(62, 96, 175, 15, -1, 0);
    do_line(70, 99, 175, 0, -1, 0);
    new_value(16'h0008);
    do_line(70, 99, 175, 0, -1, 0);
    new_value(16'h0000);
    do_line(75, 99, 175, 0, -1, 0);

    // Asynchronous reset on a lit row.
    new_value(16'h8888);
    entered = 0;
    for (int xx = 96; xx <= 110; xx++) tick(1, xx, 55, 0, 0, 0);
    rst = 0;
    #1;
    chk("arst_pix_on", 32'(pix_on), 0);
    chk("arst_pix_vld", 32'(pix_vld), 0);
    chk("arst_rom_adr", 32'(rom_adr), 0);
    model_clear();
    #2 rst = 1;
    for (int xx = 111; xx <= 175; xx++) tick(1, xx, 55, 0, 0, 0);
    tick(0, 0, 55, 0, 0, 0);
    do_line(56, 96, 175, 0, -1, 0);
    new_value(16'h1357);
    do_line(57, 96, 175, 0, -1, 0);

    // Random frames: position, value (incl. blank codes and leading zeros), en gaps, mid-frame loads.
    for (int f = 0; f < 10; f++) begin
      set_pos($urandom_range(940, 6), $urandom_range(980, 2));
      v = 16'($urandom);
      if (f % 3 == 0) v = v & 16'h00FF;
      if (f % 4 == 1) v = v & 16'h0999;
      new_value(v);
      for (int l = 0; l < 6; l++) begin
        do_line(py - 2 + $urandom_range(CH + 3, 0), px - $urandom_range(5, 0), px + 75, 25,
                (l == 2) ? px + 30 : -1, 16'($urandom));
      end
      tick(0, 0, 0, 0, 1, 0);
      do_line(py + $urandom_range(CH - 1, 0), px - 1, px + 75, 0, -1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
